// File: rtl/symbol_frame_buffer_pkg.sv
// symbol_frame_buffer_pkg: shared FSM state type and erase constant for the symbol frame buffer.
package symbol_frame_buffer_pkg;
   typedef enum logic [1:0] {FILL, FWD, REV} state_t;
   // +0.0 in any IEEE width is all zeros; sliced down to the soft value width by users.
   localparam logic [63:0] POS_ZERO = '0;
endpackage

// File: rtl/symbol_ram.sv
// symbol_ram: simple dual-port RAM with registered read.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request; rd_data valid the cycle after rd_en.
module symbol_ram #(
   parameter int W     = 32,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [W-1:0]             wr_data,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [W-1:0]             rd_data
);
   logic [W-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/symbol_frame_buffer.sv
// symbol_frame_buffer: stores one frame of soft symbols, then replays it forward and backward.
// Ports: clk, reset_n (async, active-low);
//   input  stream: in_valid/in_ready handshake, in_symbol, in_erase (store +0.0), in_last;
//   output stream: out_valid, symbol, out_index, out_reverse, out_first, out_last (all 0 when idle).
module symbol_frame_buffer
   import symbol_frame_buffer_pkg::*;
#(
   parameter int    BITS            = 16,
   parameter string PRECISION       = "HALF",
   parameter int    BITS_PER_SYMBOL = 2,
   parameter int    FRAME_LEN       = 64
) (
   input  logic                                    clk,
   input  logic                                    reset_n,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic [BITS_PER_SYMBOL-1:0][BITS-1:0]    in_symbol,
   input  logic                                    in_erase,
   input  logic                                    in_last,
   output logic                                    out_valid,
   output logic [BITS_PER_SYMBOL-1:0][BITS-1:0]    symbol,
   output logic [$clog2(FRAME_LEN)-1:0]            out_index,
   output logic                                    out_reverse,
   output logic                                    out_first,
   output logic                                    out_last
);
   localparam int AW = $clog2(FRAME_LEN);
   localparam int W  = BITS * BITS_PER_SYMBOL;
   localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);

   if (FRAME_LEN < 2 || (PRECISION != "HALF" && PRECISION != "SINGLE")) begin : g_bad_cfg
      $error("symbol_frame_buffer: FRAME_LEN must be >= 2 and PRECISION HALF or SINGLE");
   end

   state_t        state, state_d;
   logic [AW-1:0] wr_cnt, wr_cnt_d, rd_cnt, rd_cnt_d, last_idx;
   logic [AW:0]   len, len_d;
   logic          wr_en, rd_en, rev, first, last;
   logic [W-1:0]  wr_data, rd_data;

   // len == FRAME_LEN wraps to 0 in the low bits, so minus one still lands on FRAME_LEN-1.
   assign last_idx = len[AW-1:0] - 1'b1;
   assign in_ready = state == FILL;
   assign wr_data  = in_erase ? {BITS_PER_SYMBOL{POS_ZERO[BITS-1:0]}} : in_symbol;
   assign rev      = state == REV;
   assign first    = rev ? rd_cnt == last_idx : rd_cnt == '0;
   assign last     = rev ? rd_cnt == '0 : rd_cnt == last_idx;
   assign symbol   = out_valid ? rd_data : '0;

   always_comb begin
      state_d  = state;
      wr_cnt_d = wr_cnt;
      rd_cnt_d = rd_cnt;
      len_d    = len;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      unique case (state)
         FILL: if (in_valid) begin
            wr_en    = 1'b1;
            wr_cnt_d = wr_cnt + 1'b1;
            if (in_last || wr_cnt == LAST_ADDR) begin
               state_d  = FWD;
               wr_cnt_d = '0;
               rd_cnt_d = '0;
               len_d    = {1'b0, wr_cnt} + 1'b1;
            end
         end
         FWD: begin
            rd_en = 1'b1;
            // The backward pass begins by re-reading the last index, so rd_cnt is held here.
            if (rd_cnt == last_idx) state_d = REV;
            else rd_cnt_d = rd_cnt + 1'b1;
         end
         REV: begin
            rd_en = 1'b1;
            if (rd_cnt == '0) begin
               state_d  = FILL;
               wr_cnt_d = '0;
            end else rd_cnt_d = rd_cnt - 1'b1;
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= FILL;
         wr_cnt <= '0;
         rd_cnt <= '0;
         len    <= '0;
      end else begin
         state  <= state_d;
         wr_cnt <= wr_cnt_d;
         rd_cnt <= rd_cnt_d;
         len    <= len_d;
      end
   end

   // Flags travel alongside the registered RAM read so they line up with the data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid   <= 1'b0;
         out_index   <= '0;
         out_reverse <= 1'b0;
         out_first   <= 1'b0;
         out_last    <= 1'b0;
      end else begin
         out_valid   <= rd_en;
         out_index   <= rd_en ? rd_cnt : '0;
         out_reverse <= rd_en && rev;
         out_first   <= rd_en && first;
         out_last    <= rd_en && last;
      end
   end

   symbol_ram #(.W(W), .DEPTH(FRAME_LEN)) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_cnt),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (rd_cnt),
      .rd_data (rd_data)
   );
endmodule

// File: tb/tb_symbol_frame_buffer.sv
// tb_symbol_frame_buffer: table-driven frames with a scoreboard queue of expected output beats.
module tb_symbol_frame_buffer;
   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [1:0][15:0] in_symbol = '0;
   logic             in_erase = 1'b0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic [1:0][15:0] symbol;
   logic [5:0]       out_index;
   logic             out_reverse, out_first, out_last;

   symbol_frame_buffer dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_symbol   (in_symbol),
      .in_erase    (in_erase),
      .in_last     (in_last),
      .out_valid   (out_valid),
      .symbol      (symbol),
      .out_index   (out_index),
      .out_reverse (out_reverse),
      .out_first   (out_first),
      .out_last    (out_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          n;
      bit          use_last;
      int          erase_at;
      logic [15:0] base;
      logic [15:0] step;
   } vec_t;

   typedef struct {
      logic [5:0]  idx;
      bit          rev;
      bit          first;
      bit          last;
      logic [31:0] sym;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (out_valid) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got index %0d, expected no beat", out_index);
            end else begin
               e = q.pop_front();
               chk("out_index", out_index, e.idx);
               chk("out_reverse", out_reverse, e.rev);
               chk("out_first", out_first, e.first);
               chk("out_last", out_last, e.last);
               chk("symbol", symbol, e.sym);
            end
         end else begin
            chk("idle_zero", {symbol, out_index, out_first, out_last, out_reverse}, '0);
         end
      end
   end

   task automatic wait_ready();
      int k = 0;
      while (!in_ready && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("ready_timeout", in_ready, 1'b1);
   endtask

   // Drives one frame and pushes the expected forward+backward beats; optionally measures the burst.
   task automatic send_frame(input vec_t v, input bit drain);
      logic [31:0] mem [64];
      logic [15:0] val;
      exp_t        e;
      int          run;
      wait_ready();
      for (int i = 0; i < v.n; i++) begin
         val       = v.base + v.step * 16'(i);
         in_valid  = 1'b1;
         in_symbol = {val ^ 16'h8000, val};
         in_erase  = (i == v.erase_at);
         in_last   = v.use_last && (i == v.n - 1);
         mem[i]    = in_erase ? 32'h0 : {val ^ 16'h8000, val};
         @(negedge clk);
      end
      for (int i = 0; i < v.n; i++) begin
         e = '{idx: 6'(i), rev: 1'b0, first: i == 0, last: i == v.n - 1, sym: mem[i]};
         q.push_back(e);
      end
      for (int i = v.n - 1; i >= 0; i--) begin
         e = '{idx: 6'(i), rev: 1'b1, first: i == v.n - 1, last: i == 0, sym: mem[i]};
         q.push_back(e);
      end
      in_erase = 1'b0;
      in_last  = 1'b0;
      if (v.use_last) in_valid = 1'b0;
      else begin
         in_symbol = {16'hDEAD, 16'hBEEF};
         chk("hold_off_ready", in_ready, 1'b0);
      end
      if (drain) begin
         chk("latency_gap", out_valid, 1'b0);
         @(negedge clk);
         in_valid = 1'b0;
         chk("latency_first", out_valid, 1'b1);
         run = 1;
         for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!out_valid) break;
            run++;
         end
         chk("burst_len", run, 2 * v.n);
      end else in_valid = 1'b0;
   endtask

   vec_t vecs[5];

   initial begin
      int k;
      vecs[0] = '{n: 64, use_last: 1'b1, erase_at: -1, base: 16'h0000, step: 16'h0001};
      vecs[1] = '{n: 5,  use_last: 1'b1, erase_at: -1, base: 16'h4100, step: 16'h0011};
      vecs[2] = '{n: 64, use_last: 1'b0, erase_at: -1, base: 16'hC000, step: 16'h0003};
      vecs[3] = '{n: 8,  use_last: 1'b1, erase_at: 2,  base: 16'h3C00, step: 16'h0000};
      vecs[4] = '{n: 1,  use_last: 1'b1, erase_at: -1, base: 16'hBC00, step: 16'h0000};

      #3;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_outputs", {out_valid, symbol, out_index, out_first, out_last, out_reverse}, '0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      mon_en  = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         send_frame(vecs[i], 1'b1);
         @(negedge clk);
      end
      chk("queue_drained", q.size(), 0);

      // Reset in the middle of the backward pass, then replay a fresh frame.
      send_frame(vecs[0], 1'b0);
      k = 0;
      while (!(out_valid && out_reverse && out_index == 6'd30) && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("reached_rev_30", {out_valid, out_reverse, out_index}, {1'b1, 1'b1, 6'd30});
      mon_en  = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("async_rst_outputs", {out_valid, symbol, out_index, out_first, out_last, out_reverse}, '0);
      chk("async_rst_ready", in_ready, 1'b1);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      q.delete();
      mon_en = 1'b1;
      send_frame('{n: 10, use_last: 1'b1, erase_at: 7, base: 16'h1234, step: 16'h0003}, 1'b1);
      @(negedge clk);
      chk("queue_drained_after_reset", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/symbol_frame_buffer.md
SYMBOL_FRAME_BUFFER -- requirements
Module: symbol_frame_buffer

Interface
REQ-001 SHALL have parameter BITS, default 16: width of one floating-point soft value.
REQ-002 SHALL have parameter PRECISION, default "HALF": "HALF" or "SINGLE". Carried for format consistency only; values are never modified except on erasure.
REQ-003 SHALL have parameter BITS_PER_SYMBOL, default 2: soft values per symbol.
REQ-004 SHALL have parameter FRAME_LEN, default 64: maximum symbols per frame; must be at least 2.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port in_valid, input, 1: input beat offered.
REQ-008 SHALL have port in_ready, output, 1: beat accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port in_symbol, input, [BITS-1:0] x BITS_PER_SYMBOL: soft values of one symbol.
REQ-010 SHALL have port in_erase, input, 1: symbol punctured; store +0.0 (all zeros) for every value.
REQ-011 SHALL have port in_last, input, 1: final symbol of the frame.
REQ-012 SHALL have port out_valid, output, 1: drives the branch-metric in_valid.
REQ-013 SHALL have port symbol, output, [BITS-1:0] x BITS_PER_SYMBOL: drives the branch-metric symbol input.
REQ-014 SHALL have port out_index, output, clog2(FRAME_LEN): trellis step of the current output.
REQ-015 SHALL have port out_reverse, output, 1: 0 during the forward pass, 1 during the backward pass.
REQ-016 SHALL have port out_first and port out_last, output, 1 each: first and last beat of each pass.

Function
REQ-017 SHALL implement the FSM FILL -> FWD -> REV -> FILL.
REQ-018 FILL: in_ready=1; each accepted beat written to memory[wr_cnt]; wr_cnt increments.
REQ-019 SHALL leave FILL after the beat with in_last=1, or after the beat at wr_cnt=FRAME_LEN-1 regardless of in_last (forced frame end); len = wr_cnt+1 is latched.
REQ-020 FWD, REV: in_ready=0; input beats ignored.
REQ-021 FWD: emit index 0..len-1, one per cycle, no gaps.
REQ-022 REV: emit index len-1..0, one per cycle, starting the cycle after the FWD last beat.
REQ-023 After the REV beat at index 0, SHALL return to FILL with wr_cnt=0.
REQ-024 Memory read SHALL be registered: out_valid and data appear 1 cycle after the read address is issued; the first FWD beat follows the in_last acceptance by 2 cycles.
REQ-025 out_first SHALL be high on index 0 in FWD and index len-1 in REV; out_last on the opposite end.
REQ-026 len=1: the single beat SHALL carry out_first=out_last=1 in each pass.
REQ-027 When out_valid=0, symbol, out_index, out_first, out_last and out_reverse SHALL be 0.
REQ-028 Symbol values SHALL be passed bit-exact (sign, exponent, mantissa); no arithmetic.
REQ-029 No output backpressure; the consumer always accepts.

Reset
REQ-030 reset_n low SHALL asynchronously force state FILL, wr_cnt=0, len=0, in_ready=1 and all other outputs 0.
REQ-031 Reset mid-frame or mid-pass SHALL discard the frame; memory contents need no clearing.

Structure
REQ-032 Shared package SHALL hold the state enum (FILL, FWD, REV) and the +0.0 erase constant.
REQ-033 SHALL use one sub-module, symbol_ram: a simple dual-port RAM, BITS*BITS_PER_SYMBOL wide, FRAME_LEN deep, with registered read.

Verification
REQ-034 Full frame: 64 beats with values v[i]=i, in_last on i=63 -> FWD outputs 0..63, then REV outputs 63..0; 128 consecutive out_valid cycles.
REQ-035 Short frame: in_last on beat 4 -> len=5; FWD indices 0..4, REV indices 4..0; out_first/out_last flags correct.
REQ-036 No in_last: 64 beats without in_last -> forced end after beat 63; 65th beat held off with in_ready=0.
REQ-037 Erasure: in_erase on beat 2 with input 16'h3C00 -> output 16'h0000 at index 2 in both passes; other values bit-exact.
REQ-038 len=1: single beat 16'hBC00 -> two output beats (FWD, then REV), each with out_first=out_last=1.
REQ-039 Reset asserted during REV at index 30 -> outputs 0 immediately and in_ready=1; the next frame replays correctly.
